// File: rtl/ex_muldiv_if.sv
// Command, MTHI/MTLO and result signals of the EX-stage multiply/divide unit.
// The pipeline side drives commands through master; the unit uses slave.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel, mthi, mtlo, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, mthi, mtlo, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers (IDLE/RUN/FIX FSM).
// Optional MULDIV_FAST_MUL_EN: multiplies finish in a single FIX cycle.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_reg, state_next;
  logic [63:0] acc_reg;
  logic [31:0] mag_a_reg, mag_b_reg;
  logic        sign_a_reg, sign_b_reg, div_reg, dz_flag_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg, dz_reg;

  logic        in_signed, in_div, in_sign_a, in_sign_b, div_zero, accept, skip_run;
  logic [31:0] in_mag_a, in_mag_b;

  assign in_signed = ~bus.op[0];
  assign in_div    = bus.op[1];
  assign in_sign_a = in_signed & bus.a[31];
  assign in_sign_b = in_signed & bus.b[31];
  assign in_mag_a  = in_sign_a ? -bus.a : bus.a;
  assign in_mag_b  = in_sign_b ? -bus.b : bus.b;
  assign div_zero  = in_div && (bus.b == 32'd0);
  assign accept    = (state_reg == IDLE) && bus.start && !bus.cancel;

`ifdef MULDIV_FAST_MUL_EN
  assign skip_run = div_zero || !in_div;
`else
  assign skip_run = div_zero;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = skip_run ? FIX : RUN;
      RUN: begin
        if (bus.cancel)             state_next = IDLE;
        else if (cnt_reg == 6'd31)  state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration: shift-add multiply (multiplier in acc low half, shifted out LSB first)
  // or restoring divide (acc = {remainder, dividend/quotient}).
  logic [32:0] mul_sum, div_trial;
  logic [63:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? mag_a_reg : 32'd0)};
    div_trial = acc_reg[63:31] - {1'b0, mag_b_reg};
    acc_step  = {mul_sum, acc_reg[31:1]};
    if (div_reg) begin
      if (div_trial[32]) acc_step = {acc_reg[62:0], 1'b0};
      else               acc_step = {div_trial[31:0], acc_reg[30:0], 1'b1};
    end
  end

  logic [63:0] prod, prod_neg;
  logic [31:0] res_hi, res_lo;
  logic        neg;

`ifdef MULDIV_FAST_MUL_EN
  assign prod = {32'd0, mag_a_reg} * {32'd0, mag_b_reg};
`else
  assign prod = acc_reg;
`endif
  assign neg      = sign_a_reg ^ sign_b_reg;
  assign prod_neg = -prod;

  always_comb begin
    res_hi = acc_reg[63:32];
    res_lo = acc_reg[31:0];
    if (dz_flag_reg) begin
      res_hi = acc_reg[63:32];
      res_lo = acc_reg[31:0];
    end else if (div_reg) begin
      res_lo = neg        ? -acc_reg[31:0]  : acc_reg[31:0];
      res_hi = sign_a_reg ? -acc_reg[63:32] : acc_reg[63:32];
    end else begin
      {res_hi, res_lo} = neg ? prod_neg : prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      div_reg     <= 1'b0;
      dz_flag_reg <= 1'b0;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX) && !bus.cancel;
      dz_reg   <= (state_reg == FIX) && !bus.cancel && dz_flag_reg;
      if (accept) begin
        mag_a_reg   <= in_mag_a;
        mag_b_reg   <= in_mag_b;
        sign_a_reg  <= in_sign_a;
        sign_b_reg  <= in_sign_b;
        div_reg     <= in_div;
        dz_flag_reg <= div_zero;
        cnt_reg     <= '0;
        // Divide-by-zero result is staged directly in acc so FIX just copies it out.
        if (div_zero)    acc_reg <= {bus.a, 32'hFFFF_FFFF};
        else if (in_div) acc_reg <= {32'd0, in_mag_a};
        else             acc_reg <= {32'd0, in_mag_b};
      end else if (state_reg == RUN && !bus.cancel) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + 6'd1;
      end
      if (state_reg == FIX && !bus.cancel) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end else if (state_reg == IDLE && !bus.start) begin
        if (bus.mthi) hi_reg <= bus.wdata;
        if (bus.mtlo) lo_reg <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.dz   = dz_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: result table plus MTHI/MTLO, cancel and reset sequences.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ex_muldiv_if m ();
  ex_muldiv dut (.clk(clk), .rst(rst), .bus(m));

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int DZ_LAT  = 2;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    m.start = 1'b1; m.op = o; m.a = x; m.b = y;
    @(posedge clk); #1;
    m.start = 1'b0;
  endtask

  // Count edges from the start edge (inclusive) until done is seen after an edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!m.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    m.start = 0; m.op = 0; m.a = 0; m.b = 0; m.cancel = 0;
    m.mthi = 0; m.mtlo = 0; m.wdata = 0;

    vecs[0] = '{"multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT};
    vecs[1] = '{"mult_m3x7",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT};
    vecs[2] = '{"mult_m5xm6", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30,       1'b0, MUL_LAT};
    vecs[3] = '{"multu_6x7",  2'b01, 32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0, MUL_LAT};
    vecs[4] = '{"div_m7d2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
    vecs[5] = '{"div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT};
    vecs[6] = '{"div_7dm2",   2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, DIV_LAT};
    vecs[7] = '{"divu_100d7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, DIV_LAT};
    vecs[8] = '{"divu_dz",    2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, DZ_LAT};
    vecs[9] = '{"div_dz_neg", 2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, DZ_LAT};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi",   m.hi,   0);
    chk("rst_lo",   m.lo,   0);
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    chk("rst_dz",   m.dz,   0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"}, m.busy, 1);
      wait_done(lat);
      chk({vecs[i].name, "_lat"},  lat,    vecs[i].lat);
      chk({vecs[i].name, "_hi"},   m.hi,   vecs[i].hi);
      chk({vecs[i].name, "_lo"},   m.lo,   vecs[i].lo);
      chk({vecs[i].name, "_dz"},   m.dz,   vecs[i].dz);
      chk({vecs[i].name, "_idle"}, m.busy, 0);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_off"}, m.done, 0);
      $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, m.hi, m.lo, m.dz, lat);
    end

    // MTHI+MTLO together, then individual preload
    @(negedge clk); m.mthi = 1; m.mtlo = 1; m.wdata = 32'h55;
    @(posedge clk); #1; m.mthi = 0; m.mtlo = 0;
    chk("mt_both_hi", m.hi, 32'h55);
    chk("mt_both_lo", m.lo, 32'h55);
    @(negedge clk); m.mthi = 1; m.wdata = 32'h11;
    @(posedge clk); #1; m.mthi = 0;
    @(negedge clk); m.mtlo = 1; m.wdata = 32'h22;
    @(posedge clk); #1; m.mtlo = 0;
    chk("mt_hi", m.hi, 32'h11);
    chk("mt_lo", m.lo, 32'h22);
    $display("[TB] preload hi=%h lo=%h", m.hi, m.lo);

    // DIVU with MTLO while busy, then cancel at cycle 10
    launch(2'b11, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk); m.mtlo = 1; m.wdata = 32'h33;
    @(posedge clk); #1; m.mtlo = 0;
    chk("mtlo_busy_ignored", m.lo, 32'h22);
    repeat (5) @(posedge clk);
    @(negedge clk); m.cancel = 1;
    @(posedge clk); #1; m.cancel = 0;
    chk("cancel_busy", m.busy, 0);
    chk("cancel_hi",   m.hi,   32'h11);
    chk("cancel_lo",   m.lo,   32'h22);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m.done) done_cnt++;
    end
    chk("cancel_no_done", done_cnt, 0);
    chk("cancel_lo_after", m.lo, 32'h22);
    $display("[TB] cancel busy=%0d hi=%h lo=%h done_pulses=%0d", m.busy, m.hi, m.lo, done_cnt);

    // Cancel in IDLE suppresses start
    @(negedge clk); m.start = 1; m.cancel = 1; m.op = 2'b11; m.a = 32'd9; m.b = 32'd3;
    @(posedge clk); #1; m.start = 0; m.cancel = 0;
    chk("idle_cancel_busy", m.busy, 0);
    $display("[TB] idle cancel busy=%0d", m.busy);

    // Start wins over MTLO in the same cycle
    @(negedge clk); m.start = 1; m.mtlo = 1; m.wdata = 32'h99; m.op = 2'b01; m.a = 32'd3; m.b = 32'd5;
    @(posedge clk); #1; m.start = 0; m.mtlo = 0;
    chk("prio_lo_kept", m.lo, 32'h22);
    chk("prio_busy",    m.busy, 1);
    wait_done(lat);
    chk("prio_lat", lat, MUL_LAT);
    chk("prio_lo",  m.lo, 32'd15);
    $display("[TB] start+mtlo -> hi=%h lo=%h lat=%0d", m.hi, m.lo, lat);

    // Reset mid-operation
    launch(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hi",   m.hi,   0);
    chk("mid_rst_lo",   m.lo,   0);
    chk("mid_rst_busy", m.busy, 0);
    chk("mid_rst_done", m.done, 0);
    @(negedge clk); rst = 1'b0;
    launch(2'b01, 32'd6, 32'd7);
    wait_done(lat);
    chk("post_rst_lat", lat, MUL_LAT);
    chk("post_rst_hi",  m.hi, 0);
    chk("post_rst_lo",  m.lo, 32'd42);
    $display("[TB] post-reset multu 6x7 -> hi=%h lo=%h lat=%0d", m.hi, m.lo, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
